// File: rtl/backprop_train_sequencer_if.sv
// Request/row/train handshake between the training top-level, the sequencer and the
// backprop stack controller.
interface backprop_train_sequencer_if #(
  parameter int unsigned backprop_controll_size = 66
);
  logic                              req;
  logic [31:0]                       req_layers;
  logic                              row_valid;
  logic                              active_train;
  logic [backprop_controll_size-1:0] backprop_controll_bundle;
  logic                              ack;
  logic                              busy;
  logic                              done;
  logic                              err;

  modport slave (
    input  req,
    input  req_layers,
    input  row_valid,
    input  active_train,
    output backprop_controll_bundle,
    output ack,
    output busy,
    output done,
    output err
  );

  modport master (
    output req,
    output req_layers,
    output row_valid,
    output active_train,
    input  backprop_controll_bundle,
    input  ack,
    input  busy,
    input  done,
    input  err
  );
endinterface

// File: rtl/backprop_train_sequencer.sv
// Sequences one training pass (stores, start_train, train tracking, drain) for the stack
// controller. Optional TRAIN watchdog enabled by defining TRAIN_SEQ_WATCHDOG_EN.
module backprop_train_sequencer #(
  parameter int unsigned size                   = 3,
  parameter int unsigned max_layer_size         = 4,
  parameter int unsigned backprop_controll_size = 66,
  parameter int unsigned watchdog_cycles        = 64
) (
  input logic                       clk,
  input logic                       reset,
  backprop_train_sequencer_if.slave bus
);

  if (backprop_controll_size != 66 || size == 0 || watchdog_cycles < 2) begin : gen_bad_params
    $error("backprop_train_sequencer: unsupported parameter combination");
  end

  localparam logic [31:0] SizeM1   = 32'(size - 1);
  localparam logic [31:0] MaxLayer = 32'(max_layer_size);

  typedef enum logic [2:0] {
    StIdle,
    StStore,
    StLaunch,
    StArm,
    StTrain,
    StDrain
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] num_layers_q, num_layers_d;
  logic [31:0] layer_q, layer_d;
  logic [31:0] row_q, row_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        req_ok;
  logic [65:0] bundle;

`ifdef TRAIN_SEQ_WATCHDOG_EN
  localparam logic [31:0] WdLast = 32'(watchdog_cycles - 1);
  logic [31:0] wd_cnt_q, wd_cnt_d;

  // Counts ARM/TRAIN cycles since ARM entry.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == StLaunch) begin
      wd_cnt_d = '0;
    end else if (state_q == StArm || state_q == StTrain) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
    end
  end
`endif

  assign req_ok = (bus.req_layers != 32'd0) && (bus.req_layers <= MaxLayer);

  always_comb begin
    state_d      = state_q;
    num_layers_d = num_layers_q;
    layer_d      = layer_q;
    row_d        = row_q;
    drain_cnt_d  = drain_cnt_q;
    ack_d        = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          if (req_ok) begin
            state_d      = StStore;
            num_layers_d = bus.req_layers;
            layer_d      = '0;
            row_d        = '0;
            ack_d        = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StStore: begin
        if (bus.row_valid) begin
          if (row_q == SizeM1) begin
            row_d   = '0;
            layer_d = layer_q + 32'd1;
            if (layer_q == num_layers_q - 32'd1) begin
              state_d = StLaunch;
              layer_d = '0;
            end
          end else begin
            row_d = row_q + 32'd1;
          end
        end
      end
      StLaunch: state_d = StArm;
      StArm: begin
        // The stack controller must have registered training by now.
        if (bus.active_train) begin
          state_d = StTrain;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StTrain: begin
        if (!bus.active_train) begin
          done_d      = 1'b1;
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
`ifdef TRAIN_SEQ_WATCHDOG_EN
        else if (wd_cnt_q == WdLast) begin
          err_d       = 1'b1;
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
`endif
      end
      StDrain: begin
        // Let the stack controller's last phase finish before another start_train.
        if (drain_cnt_q == SizeM1) begin
          state_d = StIdle;
        end else begin
          drain_cnt_d = drain_cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      num_layers_q <= '0;
      layer_q      <= '0;
      row_q        <= '0;
      drain_cnt_q  <= '0;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef TRAIN_SEQ_WATCHDOG_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      num_layers_q <= num_layers_d;
      layer_q      <= layer_d;
      row_q        <= row_d;
      drain_cnt_q  <= drain_cnt_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef TRAIN_SEQ_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  // is_store follows row_valid combinationally; everything else comes from registers.
  always_comb begin
    bundle = '0;
    if (state_q == StStore) begin
      bundle = {bus.row_valid, 1'b0, layer_q, row_q};
    end else if (state_q == StLaunch) begin
      bundle = {1'b0, 1'b1, 64'd0};
    end
  end

  assign bus.backprop_controll_bundle = bundle;
  assign bus.ack  = ack_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_backprop_train_sequencer.sv
// Directed bench for backprop_train_sequencer: a store-count/edge-number model is compared
// against the DUT every cycle, plus hand-computed literal checks.
module tb_backprop_train_sequencer;

  localparam int SIZE = 3;
  localparam int MAXL = 4;
  localparam int WD   = 64;

  localparam int PIdle   = 0;
  localparam int PStore  = 1;
  localparam int PLaunch = 2;
  localparam int PArm    = 3;
  localparam int PTrain  = 4;
  localparam int PDrain  = 5;

  logic clk = 1'b0;
  logic reset;

  backprop_train_sequencer_if #(.backprop_controll_size(66)) bus_if ();

  backprop_train_sequencer #(
    .size                  (SIZE),
    .max_layer_size        (MAXL),
    .backprop_controll_size(66),
    .watchdog_cycles       (WD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: phase, total stores made, and edge numbers for timed events.
  int m_phase    = PIdle;
  int m_stores   = 0;
  int m_total    = 0;
  int m_arm_edge = 0;
  int m_idle_at  = 0;
  int cyc        = 0;
  bit m_ack      = 1'b0;
  bit m_done     = 1'b0;
  bit m_err      = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_ack  <= 1'b0;
    m_done <= 1'b0;
    m_err  <= 1'b0;
    if (reset) begin
      m_phase  <= PIdle;
      m_stores <= 0;
    end else begin
      case (m_phase)
        PIdle: if (bus_if.req) begin
          if (bus_if.req_layers >= 1 && bus_if.req_layers <= MAXL) begin
            m_phase  <= PStore;
            m_total  <= int'(bus_if.req_layers) * SIZE;
            m_stores <= 0;
            m_ack    <= 1'b1;
          end else begin
            m_err <= 1'b1;
          end
        end
        PStore: if (bus_if.row_valid) begin
          m_stores <= m_stores + 1;
          if (m_stores + 1 == m_total) m_phase <= PLaunch;
        end
        PLaunch: begin
          m_phase    <= PArm;
          m_arm_edge <= cyc;
        end
        PArm: begin
          if (bus_if.active_train) m_phase <= PTrain;
          else begin
            m_err   <= 1'b1;
            m_phase <= PIdle;
          end
        end
        PTrain: begin
          if (!bus_if.active_train) begin
            m_done    <= 1'b1;
            m_phase   <= PDrain;
            m_idle_at <= cyc + SIZE;
          end
`ifdef TRAIN_SEQ_WATCHDOG_EN
          else if (cyc - m_arm_edge == WD) begin
            m_err     <= 1'b1;
            m_phase   <= PDrain;
            m_idle_at <= cyc + SIZE;
          end
`endif
        end
        PDrain: if (cyc == m_idle_at) m_phase <= PIdle;
        default: m_phase <= PIdle;
      endcase
    end
  end

  function automatic logic [69:0] model_out();
    logic [65:0] b;
    b = '0;
    if (m_phase == PStore) begin
      b = {bus_if.row_valid, 1'b0, 32'(m_stores / SIZE), 32'(m_stores % SIZE)};
    end else if (m_phase == PLaunch) begin
      b = {2'b01, 64'd0};
    end
    return {b, m_ack, (m_phase != PIdle), m_done, m_err};
  endfunction

  function automatic logic [69:0] dut_out();
    return {bus_if.backprop_controll_bundle, bus_if.ack, bus_if.busy, bus_if.done, bus_if.err};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) check("cycle", dut_out(), model_out());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int l);
    bus_if.req        = 1'b1;
    bus_if.req_layers = 32'(l);
    tick();
    bus_if.req        = 1'b0;
  endtask

  task automatic stores(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.row_valid = 1'b1;
      tick();
    end
    bus_if.row_valid = 1'b0;
  endtask

  // Called in the LAUNCH cycle; returns in the first DRAIN cycle.
  task automatic train(input int hi);
    tick();
    bus_if.active_train = 1'b1;
    repeat (hi) tick();
    bus_if.active_train = 1'b0;
    tick();
  endtask

  initial begin
    reset               = 1'b1;
    bus_if.req          = 1'b0;
    bus_if.req_layers   = '0;
    bus_if.row_valid    = 1'b0;
    bus_if.active_train = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    #2 check("reset_outputs", dut_out(), 70'd0);
    reset = 1'b0;

    // Nominal pass, L=2.
    request(2);
    #2 check("nominal_ack_busy", 70'({bus_if.ack, bus_if.busy}), 70'(2'b11));
    for (int i = 0; i < 6; i++) begin
      bus_if.row_valid = 1'b1;
      #2;
      if (i == 3) check("store4", 70'(bus_if.backprop_controll_bundle),
                        70'({1'b1, 1'b0, 32'd1, 32'd0}));
      if (i == 5) check("store6", 70'(bus_if.backprop_controll_bundle),
                        70'({1'b1, 1'b0, 32'd1, 32'd2}));
      tick();
    end
    bus_if.row_valid = 1'b0;
    #2 check("launch", 70'(bus_if.backprop_controll_bundle), 70'({2'b01, 64'd0}));
    train(12);
    #2 check("done_pulse", 70'({bus_if.done, bus_if.busy}), 70'(2'b11));
    repeat (SIZE) tick();
    #2 check("busy_fall", 70'(bus_if.busy), 70'd0);

    // Invalid requests.
    request(0);
    #2 check("reject0", 70'({bus_if.ack, bus_if.busy, bus_if.err}), 70'(3'b001));
    tick();
    request(5);
    #2 check("reject5", 70'({bus_if.ack, bus_if.busy, bus_if.err}), 70'(3'b001));
    tick();

    // Gapped row_valid, L=1.
    request(1);
    bus_if.row_valid = 1'b1; tick();
    bus_if.row_valid = 1'b0;
    #2 check("gap_hold", 70'(bus_if.backprop_controll_bundle), 70'({2'b00, 32'd0, 32'd1}));
    tick();
    bus_if.row_valid = 1'b1; tick();
    bus_if.row_valid = 1'b0; tick();
    bus_if.row_valid = 1'b1; tick();
    bus_if.row_valid = 1'b0;
    #2 check("gap_launch", 70'(bus_if.backprop_controll_bundle), 70'({2'b01, 64'd0}));
    train(6);
    repeat (SIZE) tick();

    // Request while busy.
    request(1);
    stores(3);
    tick();
    bus_if.active_train = 1'b1;
    tick();
    bus_if.req          = 1'b1;
    bus_if.req_layers   = 32'd1;
    tick();
    bus_if.req          = 1'b0;
    #2 check("busy_req_ignored", 70'({bus_if.ack, bus_if.err, bus_if.busy}), 70'(3'b001));
    repeat (4) tick();
    bus_if.active_train = 1'b0;
    tick();
    #2 check("busy_req_done", 70'(bus_if.done), 70'd1);
    repeat (SIZE) tick();
    request(1);
    #2 check("re_ack", 70'(bus_if.ack), 70'd1);
    stores(3);
    train(6);
    repeat (SIZE) tick();

    // Reset after the 4th store.
    request(2);
    stores(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2 check("reset_mid", dut_out(), 70'd0);
    request(1);
    bus_if.row_valid = 1'b1;
    #2 check("restart00", 70'(bus_if.backprop_controll_bundle), 70'({2'b10, 64'd0}));
    tick();
    stores(2);
    train(6);
    repeat (SIZE) tick();

    // active_train missing in ARM.
    request(1);
    stores(3);
    tick();
    tick();
    #2 check("arm_miss", 70'({bus_if.err, bus_if.busy, bus_if.done}), 70'(3'b100));
    tick();

`ifdef TRAIN_SEQ_WATCHDOG_EN
    request(1);
    stores(3);
    tick();
    bus_if.active_train = 1'b1;
    repeat (WD - 1) tick();
    #2 check("wd_quiet", 70'(bus_if.err), 70'd0);
    tick();
    #2 check("wd_err", 70'({bus_if.err, bus_if.done, bus_if.busy}), 70'(3'b101));
    repeat (SIZE) tick();
    #2 check("wd_busy_fall", 70'(bus_if.busy), 70'd0);
    bus_if.active_train = 1'b0;
    tick();
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
